// File: rtl/vp_frame_ctrl.sv
// Frame-level sequencer for the grayscale -> line buffer -> sobel -> FIFO pipeline.
// Flushes the pipeline, admits exactly one frame of pixels, drains it and reports done/error.
module vp_frame_ctrl #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int SOBEL_TRIM = 1280,
    parameter int RST_CYC    = 4,
    parameter int DRAIN_TO   = 4096
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_threshold,
    input  logic       i_bypass,
    input  logic       i_in_valid,
    input  logic       i_in_ready,
    input  logic       i_out_valid,
    input  logic       i_out_ready,
    output logic       o_pipe_rstn,
    output logic       o_pipe_en,
    output logic [7:0] o_threshold,
    output logic       o_bypass,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_frame_err,
    output logic [8:0] o_line
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int ROW_W = 9;
    localparam int TMR_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
    localparam int ARM_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [CNT_W-1:0] EXP_BYP  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] EXP_SOB  = CNT_W'(TOTAL - SOBEL_TRIM);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TO - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_pipe_rstn;
    logic              r_pipe_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [7:0]        r_threshold;
    logic              r_bypass;

    logic [ARM_W-1:0]  r_arm_cnt;
    logic [CNT_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [TMR_W-1:0]  r_timer;

    logic              w_in_beat;
    logic              w_out_beat;
    logic              w_last_beat;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_expected;
    logic [CNT_W-1:0]  w_out_cnt_next;

    logic              w_pipe_rstn_next;
    logic              w_pipe_en_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_err_next;

    assign w_in_beat   = i_in_valid & i_in_ready & r_pipe_en;
    assign w_out_beat  = i_out_valid & i_out_ready;
    assign w_last_beat = w_in_beat && (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_expected  = r_bypass ? EXP_BYP : EXP_SOB;
    // A handshake on the deadline cycle still counts as progress.
    assign w_timeout   = (r_timer == TMR_LAST) && !w_out_beat;

    always_comb begin
        w_out_cnt_next = r_out_cnt;
        if ((r_state == S_RUN || r_state == S_DRAIN) && w_out_beat) begin
            w_out_cnt_next = r_out_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_ARM;
            end
            S_ARM: begin
                if (i_abort)                    w_state_next = S_ERR;
                else if (r_arm_cnt == ARM_LAST) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (i_abort)          w_state_next = S_ERR;
                else if (w_last_beat) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Completion wins over a timeout landing on the same cycle.
                if (i_abort)                           w_state_next = S_ERR;
                else if (w_out_cnt_next == w_expected) w_state_next = S_DONE;
                else if (w_timeout)                    w_state_next = S_ERR;
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers match the state they describe.
    always_comb begin
        w_pipe_rstn_next = 1'b1;
        w_pipe_en_next   = 1'b0;
        w_busy_next      = (w_state_next != S_IDLE);
        w_done_next      = (w_state_next == S_DONE);
        w_err_next       = (w_state_next == S_ERR);
        case (w_state_next)
            S_ARM:   w_pipe_rstn_next = 1'b0;
            S_RUN:   w_pipe_en_next   = 1'b1;
            S_ERR:   w_pipe_rstn_next = 1'b0;
            default: w_pipe_en_next   = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_pipe_rstn <= 1'b0;
            r_pipe_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_threshold <= 8'd0;
            r_bypass    <= 1'b0;
            r_arm_cnt   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_out_cnt   <= '0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pipe_rstn <= w_pipe_rstn_next;
            r_pipe_en   <= w_pipe_en_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;

            if (r_state == S_IDLE && i_start) begin
                r_threshold <= i_threshold;
                r_bypass    <= i_bypass;
            end

            r_arm_cnt <= (r_state == S_ARM) ? r_arm_cnt + ARM_W'(1) : '0;

            if (r_state == S_ARM) begin
                r_col     <= '0;
                r_row     <= '0;
                r_out_cnt <= '0;
            end else begin
                r_out_cnt <= w_out_cnt_next;
                if (r_state == S_RUN && w_in_beat) begin
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + CNT_W'(1);
                    end
                end
            end

            if (r_state == S_DRAIN) begin
                r_timer <= w_out_beat ? '0 : r_timer + TMR_W'(1);
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign o_pipe_rstn  = r_pipe_rstn;
    assign o_pipe_en    = r_pipe_en;
    assign o_threshold  = r_threshold;
    assign o_bypass     = r_bypass;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;
    assign o_line       = r_row;

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Directed bench for vp_frame_ctrl on an 8x4 frame with short flush and drain timeout.
module tb_vp_frame_ctrl;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 4;
    localparam int SOBEL_TRIM = 16;
    localparam int RST_CYC    = 4;
    localparam int DRAIN_TO   = 8;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       abort;
    logic [7:0] thr;
    logic       byp;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       pipe_rstn;
    logic       pipe_en;
    logic [7:0] o_thr;
    logic       o_byp;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] line;

    int errors = 0;
    int checks = 0;

    vp_frame_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SOBEL_TRIM(SOBEL_TRIM),
        .RST_CYC(RST_CYC), .DRAIN_TO(DRAIN_TO)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort),
        .i_threshold(thr), .i_bypass(byp),
        .i_in_valid(in_valid), .i_in_ready(in_ready),
        .i_out_valid(out_valid), .i_out_ready(out_ready),
        .o_pipe_rstn(pipe_rstn), .o_pipe_en(pipe_en),
        .o_threshold(o_thr), .o_bypass(o_byp), .o_busy(busy),
        .o_frame_done(done), .o_frame_err(err), .o_line(line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] t, input logic b);
        start = 1'b1; thr = t; byp = b;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_in(input int n);
        in_valid = 1'b1;
        repeat (n) tick();
        in_valid = 1'b0;
    endtask

    task automatic feed_out(input int n);
        out_valid = 1'b1;
        repeat (n) tick();
        out_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; abort = 1'b0; thr = 8'hA5; byp = 1'b1;
        in_valid = 1'b0; in_ready = 1'b1; out_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (pipe_rstn !== 1'b0) begin errors++; $display("FAIL rst_pipe_rstn got %b want 0", pipe_rstn); end
        checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL rst_pipe_en got %b want 0", pipe_en); end
        checks++; if (o_thr !== 8'h00) begin errors++; $display("FAIL rst_threshold got %h want 00", o_thr); end
        checks++; if (o_byp !== 1'b0) begin errors++; $display("FAIL rst_bypass got %b want 0", o_byp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%b err=%b want 0/0", done, err); end
        checks++; if (line !== 9'd0) begin errors++; $display("FAIL rst_line got %0d want 0", line); end
        rstn = 1'b1; start = 1'b0;
        tick();
        checks++; if (pipe_rstn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst got rstn=%b busy=%b want 1/0", pipe_rstn, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL idle_abort got busy=%b err=%b want 0/0", busy, err); end
        $display("test_reset complete");
    endtask

    task automatic test_bypass_frame();
        do_start(8'h11, 1'b1);
        checks++; if (busy !== 1'b1 || pipe_rstn !== 1'b0 || pipe_en !== 1'b0) begin errors++; $display("FAIL t1_arm got busy=%b rstn=%b en=%b want 1/0/0", busy, pipe_rstn, pipe_en); end
        checks++; if (o_thr !== 8'h11 || o_byp !== 1'b1) begin errors++; $display("FAIL t1_latch got thr=%h byp=%b want 11/1", o_thr, o_byp); end
        repeat (RST_CYC - 1) tick();
        checks++; if (pipe_en !== 1'b0 || pipe_rstn !== 1'b0) begin errors++; $display("FAIL t1_arm_len got en=%b rstn=%b want 0/0", pipe_en, pipe_rstn); end
        tick();
        checks++; if (pipe_en !== 1'b1 || pipe_rstn !== 1'b1) begin errors++; $display("FAIL t1_run_entry got en=%b rstn=%b want 1/1", pipe_en, pipe_rstn); end
        in_valid = 1'b1;
        repeat (31) tick();
        checks++; if (pipe_en !== 1'b1 || line !== 9'd3) begin errors++; $display("FAIL t1_beat31 got en=%b line=%0d want 1/3", pipe_en, line); end
        tick();
        checks++; if (pipe_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t1_beat32 got en=%b busy=%b want 0/1", pipe_en, busy); end
        tick();
        in_valid = 1'b0;
        out_valid = 1'b1;
        repeat (31) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_early_done got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL t1_done got done=%b err=%b want 1/0", done, err); end
        tick();
        out_valid = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_idle got done=%b busy=%b want 0/0", done, busy); end
        $display("test_bypass_frame complete");
    endtask

    task automatic test_sobel_frame();
        do_start(8'h22, 1'b0);
        repeat (RST_CYC) tick();
        in_valid = 1'b1;
        repeat (24) tick();
        out_valid = 1'b1;
        repeat (8) tick();
        in_valid = 1'b0;
        checks++; if (pipe_en !== 1'b0 || o_byp !== 1'b0) begin errors++; $display("FAIL t2_drain got en=%b byp=%b want 0/0", pipe_en, o_byp); end
        repeat (7) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t2_early_done got %b want 0", done); end
        tick();
        out_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done got %b want 1", done); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t2_idle got done=%b busy=%b want 0/0", done, busy); end
        $display("test_sobel_frame complete");
    endtask

    task automatic test_config_latch();
        do_start(8'h40, 1'b1);
        thr = 8'h90; byp = 1'b0;
        repeat (RST_CYC) tick();
        feed_in(10);
        checks++; if (o_thr !== 8'h40 || o_byp !== 1'b1) begin errors++; $display("FAIL t3_hold got thr=%h byp=%b want 40/1", o_thr, o_byp); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (o_thr !== 8'h40 || pipe_en !== 1'b1) begin errors++; $display("FAIL t3_start_ignored got thr=%h en=%b want 40/1", o_thr, pipe_en); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (err !== 1'b1 || pipe_rstn !== 1'b0) begin errors++; $display("FAIL t3_abort got err=%b rstn=%b want 1/0", err, pipe_rstn); end
        tick();
        checks++; if (busy !== 1'b0 || o_thr !== 8'h40) begin errors++; $display("FAIL t3_idle got busy=%b thr=%h want 0/40", busy, o_thr); end
        do_start(8'h90, 1'b0);
        checks++; if (o_thr !== 8'h90 || o_byp !== 1'b0) begin errors++; $display("FAIL t3_relatch got thr=%h byp=%b want 90/0", o_thr, o_byp); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_arm_abort got err=%b want 1", err); end
        tick();
        $display("test_config_latch complete");
    endtask

    task automatic test_drain_timeout();
        do_start(8'h33, 1'b1);
        repeat (RST_CYC) tick();
        feed_in(32);
        feed_out(10);
        repeat (7) tick();
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t4_early_err got err=%b busy=%b want 0/1", err, busy); end
        tick();
        checks++; if (err !== 1'b1 || pipe_rstn !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t4_timeout got err=%b rstn=%b done=%b want 1/0/0", err, pipe_rstn, done); end
        tick();
        checks++; if (err !== 1'b0 || pipe_rstn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t4_idle got err=%b rstn=%b busy=%b want 0/1/0", err, pipe_rstn, busy); end
        $display("test_drain_timeout complete");
    endtask

    task automatic test_abort_restart();
        do_start(8'h55, 1'b1);
        repeat (RST_CYC) tick();
        in_valid = 1'b1;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        checks++; if (err !== 1'b1 || pipe_en !== 1'b0 || pipe_rstn !== 1'b0) begin errors++; $display("FAIL t5_abort got err=%b en=%b rstn=%b want 1/0/0", err, pipe_en, pipe_rstn); end
        tick();
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL t5_idle got busy=%b err=%b want 0/0", busy, err); end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b1 || err !== 1'b0 || pipe_rstn !== 1'b0) begin errors++; $display("FAIL t5_start_abort got busy=%b err=%b rstn=%b want 1/0/0", busy, err, pipe_rstn); end
        repeat (RST_CYC) tick();
        checks++; if (pipe_en !== 1'b1 || line !== 9'd0) begin errors++; $display("FAIL t5_rerun got en=%b line=%0d want 1/0", pipe_en, line); end
        feed_in(7);
        checks++; if (line !== 9'd0) begin errors++; $display("FAIL t5_col7 got line=%0d want 0", line); end
        feed_in(1);
        checks++; if (line !== 9'd1) begin errors++; $display("FAIL t5_col8 got line=%0d want 1", line); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        $display("test_abort_restart complete");
    endtask

    task automatic test_reset_mid_drain();
        do_start(8'h77, 1'b1);
        repeat (RST_CYC) tick();
        feed_in(32);
        feed_out(3);
        rstn = 1'b0;
        tick();
        checks++; if (pipe_rstn !== 1'b0 || pipe_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_ctrl got rstn=%b en=%b busy=%b want 0/0/0", pipe_rstn, pipe_en, busy); end
        checks++; if (o_thr !== 8'h00 || o_byp !== 1'b0 || line !== 9'd0) begin errors++; $display("FAIL t6_cfg got thr=%h byp=%b line=%0d want 00/0/0", o_thr, o_byp, line); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL t6_pulses got done=%b err=%b want 0/0", done, err); end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_quiet%0d got done=%b err=%b busy=%b want 0/0/0", i, done, err, busy); end
        end
        $display("test_reset_mid_drain complete");
    endtask

    initial begin
        test_reset();
        test_bypass_frame();
        test_sobel_frame();
        test_config_latch();
        test_drain_timeout();
        test_abort_restart();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
